// File: rtl/decode_queue_pkg.sv
// core: shared RV32I decode encodings, queue entry type and helpers.
// RV32M_EN adds the multiply/divide ALU ops.
package core;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [6:0] F7_MULDIV  = 7'h01;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
`ifdef RV32M_EN
    , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
  } alu_op_t;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_t;
  typedef enum logic [2:0] {OP2_RS2, OP2_I_IMM, OP2_S_IMM, OP2_U_IMM, OP2_FOUR} op2_t;
  typedef struct packed {
    alu_op_t alu;
    op1_t    op1;
    op2_t    op2;
    logic    reg_en;
    logic    mem_rd;
    logic    mem_wr;
    logic    branch;
    logic    jump;
    logic    jalr;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        illegal;
  } entry_t;
  typedef enum logic {RUN, HALT} state_t;
  function automatic alu_op_t base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000: return alt ? ALU_SUB : ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return alt ? ALU_SRA : ALU_SRL;
      3'b110: return ALU_OR;
      3'b111: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: upstream instruction handshake and downstream decoded-entry handshake.
interface decode_queue_if;
  import core::*;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  ctrl_t       out_ctrl;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic        out_illegal;
  modport master (output in_valid, in_insn, in_pc, out_ready,
                  input in_ready, out_valid, out_ctrl, out_insn, out_pc, out_illegal);
  modport slave (input in_valid, in_insn, in_pc, out_ready,
                 output in_ready, out_valid, out_ctrl, out_insn, out_pc, out_illegal);
endinterface

// File: rtl/decode_queue_insn_decode.sv
// insn_decode: combinational RV32I decoder; RV32M_EN enables OP funct7=0x01 mul/div.
module insn_decode
  import core::*;
(
  input  logic [31:0] insn,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       bad;
  ctrl_t      c;
  logic       unused_fields;
  assign opc = insn[6:0];
  assign f3 = insn[14:12];
  assign f7 = insn[31:25];
  assign unused_fields = ^{insn[24:15], insn[11:7]};
  always_comb begin
    c = CTRL_NOP;
    bad = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        // only the shift-right encoding uses funct7 to pick the arithmetic variant
        c.alu = base_alu(f3, f3 == F3_SR && f7 == F7_ALT);
        c.op2 = OP2_I_IMM;
        c.reg_en = 1'b1;
        bad = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
      end
      OPC_OP: begin
        c.alu = base_alu(f3, f7 == F7_ALT);
        c.reg_en = 1'b1;
        bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
`ifdef RV32M_EN
        if (f7 == F7_MULDIV) begin
          c.alu = alu_op_t'(ALU_MUL + 5'(f3));
          bad = 1'b0;
        end
`endif
      end
      OPC_LUI: begin
        c.op1 = OP1_ZERO;
        c.op2 = OP2_U_IMM;
        c.reg_en = 1'b1;
      end
      OPC_AUIPC: begin
        c.op1 = OP1_PC;
        c.op2 = OP2_U_IMM;
        c.reg_en = 1'b1;
      end
      OPC_JAL: begin
        c.op1 = OP1_PC;
        c.op2 = OP2_FOUR;
        c.reg_en = 1'b1;
        c.jump = 1'b1;
      end
      OPC_JALR: begin
        c.op1 = OP1_PC;
        c.op2 = OP2_FOUR;
        c.reg_en = 1'b1;
        c.jump = 1'b1;
        c.jalr = 1'b1;
        bad = f3 != F3_ADD;
      end
      OPC_BRANCH: begin
        c.alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        c.branch = 1'b1;
        bad = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        c.op2 = OP2_I_IMM;
        c.reg_en = 1'b1;
        c.mem_rd = 1'b1;
        bad = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        c.op2 = OP2_S_IMM;
        c.mem_wr = 1'b1;
        bad = f3[2] || f3 == 3'b011;
      end
      default: bad = 1'b1;
    endcase
  end
  assign ctrl = bad ? CTRL_NOP : c;
  assign illegal = bad;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes incoming instructions into a DEPTH-entry FIFO, halting after an illegal one.
// RV32M_EN (via core/insn_decode) makes mul/div encodings legal.
module decode_queue
  import core::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  decode_queue_if.slave    bus,
  output logic [CNT_W-1:0] illegal_count
);
  localparam int AW = $clog2(DEPTH);
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd, wr;
  logic [AW:0]   cnt;
  state_t        state, state_nx;
  ctrl_t         dec_ctrl;
  logic          dec_ill, acc, pop;
  insn_decode u_dec (.insn(bus.in_insn), .ctrl(dec_ctrl), .illegal(dec_ill));
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else state <= state_nx;
  end
  always_comb state_nx = flush ? RUN : (state == RUN && acc && dec_ill) ? HALT : state;
  // cnt[AW] is the full flag since DEPTH is a power of two
  always_comb bus.in_ready = !cnt[AW] && state == RUN && !flush;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      illegal_count <= '0;
    end else begin
      if (flush) begin
        rd <= '0;
        wr <= '0;
        cnt <= '0;
      end else begin
        rd <= rd + AW'(pop);
        wr <= wr + AW'(acc);
        cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop);
      end
      if (acc && dec_ill && !(&illegal_count)) illegal_count <= illegal_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wr] <= '{ctrl: dec_ctrl, insn: bus.in_insn, pc: bus.in_pc, illegal: dec_ill};
  end
  // storage is never reset, so an empty queue presents a zeroed (NOP) entry
  assign bus.out_valid = cnt != '0;
  assign head = bus.out_valid ? mem[rd] : '0;
  assign bus.out_ctrl = head.ctrl;
  assign bus.out_insn = head.insn;
  assign bus.out_pc = head.pc;
  assign bus.out_illegal = head.illegal;
endmodule
